// File: rtl/me_pkg.sv
// Shared types and compare rule for the motion-estimation SAD argmin path.
// Optional build macro used by the design: ME_TREE_PIPE_EN (registers each tree level).
package me_pkg;

    localparam int unsigned ME_SAD_W    = 14;
    localparam int unsigned ME_NUM_CAND = 16;
    localparam int unsigned ME_NUM_ROWS = 16;
    localparam int unsigned ME_IDX_W    = $clog2(ME_NUM_CAND);

    typedef logic [ME_SAD_W-1:0] sad_t;

    typedef struct packed {
        logic                valid;
        sad_t                sad;
        logic [ME_IDX_W-1:0] idx;
    } cand_t;

    function automatic logic sad_lt(input logic [31:0] a, input logic [31:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/sad_min2.sv
// One compare-tree node: keeps the left operand unless the right is strictly smaller.
// With ME_TREE_PIPE_EN defined the node result is registered under the advance enable.
module sad_min2
    import me_pkg::*;
#(
    parameter int unsigned SAD_W   = ME_SAD_W,
    parameter int unsigned IDX_W   = ME_IDX_W,
    parameter int unsigned SEL_BIT = 0
) (
`ifdef ME_TREE_PIPE_EN
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_flush,
`endif
    input  logic             i_l_valid,
    input  logic [SAD_W-1:0] i_l_sad,
    input  logic [IDX_W-1:0] i_l_idx,
    input  logic             i_r_valid,
    input  logic [SAD_W-1:0] i_r_sad,
    input  logic [IDX_W-1:0] i_r_idx,
    output logic             o_valid,
    output logic [SAD_W-1:0] o_sad,
    output logic [IDX_W-1:0] o_idx
);

    logic             w_sel;
    logic             w_valid;
    logic [SAD_W-1:0] w_sad;
    logic [IDX_W-1:0] w_idx;

    // Select the smaller operand and record the chosen side in this level's index bit
    always_comb begin
        w_sel   = sad_lt(32'(i_r_sad), 32'(i_l_sad));
        w_valid = i_l_valid & i_r_valid;
        w_sad   = w_sel ? i_r_sad : i_l_sad;
        w_idx   = (w_sel ? i_r_idx : i_l_idx) | (IDX_W'(w_sel) << SEL_BIT);
    end

`ifdef ME_TREE_PIPE_EN
    logic             r_valid;
    logic [SAD_W-1:0] r_sad;
    logic [IDX_W-1:0] r_idx;

    // Level register: flush kills the valid, stall holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sad   <= '0;
            r_idx   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= w_valid;
            r_sad   <= w_sad;
            r_idx   <= w_idx;
        end
    end

    assign o_valid = r_valid;
    assign o_sad   = r_sad;
    assign o_idx   = r_idx;
`else
    assign o_valid = w_valid;
    assign o_sad   = w_sad;
    assign o_idx   = w_idx;
`endif

endmodule

// File: rtl/sad_argmin_pipe.sv
// Minimum-SAD selector: per-row compare tree, then a running minimum over NUM_ROWS rows,
// emitting {sad, mv_x, mv_y} once per block under valid/ready.
// Build macro: ME_TREE_PIPE_EN adds a register after every tree level (latency LEVELS+1).
module sad_argmin_pipe
    import me_pkg::*;
#(
    parameter  int unsigned SAD_W    = ME_SAD_W,
    parameter  int unsigned NUM_CAND = ME_NUM_CAND,
    parameter  int unsigned NUM_ROWS = ME_NUM_ROWS,
    localparam int unsigned IDX_W    = $clog2(NUM_CAND),
    localparam int unsigned ROW_W    = $clog2(NUM_ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CAND*SAD_W-1:0] in_sad,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SAD_W-1:0]          out_sad,
    output logic [IDX_W-1:0]          out_mv_x,
    output logic [ROW_W-1:0]          out_mv_y
);

    logic             w_en;
    logic             w_take;
    logic             w_last;
    logic             w_upd;
    logic [SAD_W-1:0] w_cand_sad;
    logic [IDX_W-1:0] w_cand_x;
    logic [ROW_W-1:0] w_cand_y;

    logic [ROW_W-1:0] r_row_cnt;
    logic [SAD_W-1:0] r_best_sad;
    logic [IDX_W-1:0] r_best_x;
    logic [ROW_W-1:0] r_best_y;
    logic             r_out_valid;
    logic [SAD_W-1:0] r_out_sad;
    logic [IDX_W-1:0] r_out_x;
    logic [ROW_W-1:0] r_out_y;

    assign w_en     = !(r_out_valid & !out_ready);
    assign in_ready = w_en;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2, leaves hold candidates in order
    for (genvar n = 0; n < 2*NUM_CAND-1; n++) begin : g_nd
        logic             w_valid;
        logic [SAD_W-1:0] w_sad;
        logic [IDX_W-1:0] w_idx;
        if (n >= NUM_CAND-1) begin : g_leaf
            assign w_valid = in_valid;
            assign w_sad   = in_sad[(n-(NUM_CAND-1))*SAD_W +: SAD_W];
            assign w_idx   = '0;
        end else begin : g_node
            localparam int unsigned DEPTH = $clog2(n+2) - 1;
            sad_min2 #(
                .SAD_W   (SAD_W),
                .IDX_W   (IDX_W),
                .SEL_BIT (IDX_W - 1 - DEPTH)
            ) u_min2 (
`ifdef ME_TREE_PIPE_EN
                .clk       (clk),
                .rst_n     (rst_n),
                .i_en      (w_en),
                .i_flush   (flush),
`endif
                .i_l_valid (g_nd[2*n+1].w_valid),
                .i_l_sad   (g_nd[2*n+1].w_sad),
                .i_l_idx   (g_nd[2*n+1].w_idx),
                .i_r_valid (g_nd[2*n+2].w_valid),
                .i_r_sad   (g_nd[2*n+2].w_sad),
                .i_r_idx   (g_nd[2*n+2].w_idx),
                .o_valid   (w_valid),
                .o_sad     (w_sad),
                .o_idx     (w_idx)
            );
        end
    end

    // Running-minimum candidate: first row loads, later rows win only when strictly smaller
    always_comb begin
        w_take     = g_nd[0].w_valid & w_en & !flush;
        w_last     = (r_row_cnt == ROW_W'(NUM_ROWS-1));
        w_upd      = (r_row_cnt == '0) | sad_lt(32'(g_nd[0].w_sad), 32'(r_best_sad));
        w_cand_sad = r_best_sad;
        w_cand_x   = r_best_x;
        w_cand_y   = r_best_y;
        if (w_upd) begin
            w_cand_sad = g_nd[0].w_sad;
            w_cand_x   = g_nd[0].w_idx;
            w_cand_y   = r_row_cnt;
        end
    end

    // Accumulator and row counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_cnt  <= '0;
            r_best_sad <= '0;
            r_best_x   <= '0;
            r_best_y   <= '0;
        end else if (flush) begin
            r_row_cnt <= '0;
        end else if (w_take) begin
            r_best_sad <= w_cand_sad;
            r_best_x   <= w_cand_x;
            r_best_y   <= w_cand_y;
            r_row_cnt  <= w_last ? '0 : r_row_cnt + ROW_W'(1);
        end
    end

    // Result register: new block result loads, otherwise a handshake retires it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sad   <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else if (w_take && w_last) begin
            r_out_valid <= 1'b1;
            r_out_sad   <= w_cand_sad;
            r_out_x     <= w_cand_x;
            r_out_y     <= w_cand_y;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sad   = r_out_sad;
    assign out_mv_x  = r_out_x;
    assign out_mv_y  = r_out_y;

endmodule

// File: doc/sad_argmin_pipe.md
# sad_argmin_pipe

Pipelined, parametrised minimum-SAD selector for the motion-estimation core. Each accepted beat carries one search row of NUM_CAND SAD candidates. A log2-depth compare tree reduces each row to its minimum, and a running-minimum stage tracks the best row over NUM_ROWS beats. Once per block it emits the winning SAD with a 2-D motion vector (x = candidate index, y = row index), under valid/ready flow control.

## Interface
- SAD_W, 14: unsigned SAD width.
- NUM_CAND, 16: candidates per row; power of two, ≥ 2.
- NUM_ROWS, 16: rows per block search; ≥ 2.
- IDX_W, $clog2(NUM_CAND): derived, not overridable.
- ROW_W, $clog2(NUM_ROWS): derived, not overridable.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current block.
- in_valid  in  1  row beat valid.
- in_ready  out  1  row beat accepted when in_valid & in_ready.
- in_sad  in  NUM_CAND*SAD_W  candidate i at bits [i*SAD_W +: SAD_W].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_sad  out  SAD_W  block minimum SAD.
- out_mv_x  out  IDX_W  winning candidate index.
- out_mv_y  out  ROW_W  winning row index.

## Operation
- All SADs are unsigned; there is no arithmetic. Comparisons are strict less-than on SAD_W bits.
- Tree node: output the right operand only if right < left; otherwise output the left operand. Ties therefore resolve to the lower candidate index.
- Index growth: each level prepends one bit (0 = left, 1 = right), so the root index equals the candidate's position 0..NUM_CAND-1.
- Valid bits travel with data through every stage. Bubbles are allowed.
- Accumulator stage, on a valid row:
  - row_cnt == 0: load {sad, idx, 0} unconditionally.
  - Otherwise: replace the held value only if row_sad < held sad, so ties keep the earlier row.
  - Then increment row_cnt.
- When the row at row_cnt == NUM_ROWS-1 is processed:
  - The final minimum (including that row) loads the output register and sets out_valid.
  - row_cnt wraps to 0.
  - The next block's rows follow with no gap.
- Global advance enable en = !(out_valid & !out_ready). All pipeline, accumulator and row_cnt registers hold when en = 0. in_ready = en (combinational from out_ready).
- out_valid clears on handshake unless a new result loads in the same cycle; in that case it stays 1 with the new data.
- flush (priority over everything except reset):
  - Clears all pipeline valid bits and row_cnt.
  - Does not touch a pending output; out_valid/out_* are preserved.
  - A beat presented with flush high is dropped.
- Reset values: out_valid 0, out_sad 0, out_mv_x 0, out_mv_y 0, row_cnt 0, all stage valids 0. After reset, in_ready = 1.

## Timing
- Throughput: one row per cycle while en = 1.
- Latency from the last row's accept edge to out_valid high:
  - LEVELS+1 cycles with ME_TREE_PIPE_EN, where LEVELS = log2(NUM_CAND).
  - 1 cycle without it.
- Stall is lossless: holding out_ready low for any number of cycles loses no accepted row, and no in_ready-high beat is ignored.
- A reset assertion mid-block discards all state asynchronously. The first row after release is row 0.

## Configuration
- ME_TREE_PIPE_EN defined: a register (data, index, valid) sits after every tree level. Fmax-oriented; latency LEVELS+1.
- ME_TREE_PIPE_EN undefined: the tree is fully combinational into the accumulator. Latency 1.
- Functional results are identical in both builds; only latency differs.

## Structure
- Package me_pkg:
  - SAD_W default constant.
  - typedef sad_t (logic [SAD_W-1:0]).
  - Candidate struct {valid, sad, idx} parametrised via localparam widths.
  - The shared strict-less tie rule documented as a constant comment-free function sad_lt.
- Sub-module sad_min2: one tree node. It compares two {valid, sad, idx} inputs, prepends the select bit, and optionally registers under ME_TREE_PIPE_EN with en. A generate loop instantiates NUM_CAND-1 nodes.

## Test plan
- Defaults. One block where row 5 has candidate 9 = 3 and all other SADs are 100. Expect out_sad = 3, mv_x = 9, mv_y = 5, exactly once after 16 rows.
- Ties. All SADs equal 50 in every row. Expect mv_x = 0, mv_y = 0. Then rows 2 and 7 both contain 10 at index 4. Expect mv_y = 2, mv_x = 4.
- Backpressure. Keep out_ready low for 20 cycles with back-to-back blocks. Expect in_ready low once out_valid is set, no row lost, and the second block's result correct after release.
- Flush. Pulse flush after row 8 of a block containing minimum 1 at row 3. Then send a fresh 16-row block with minimum 7 at (x=2, y=11). Expect a single result of 7/2/11.
- Async reset mid-block. Assert rst_n low for 2 cycles at row 10. Expect all outputs 0 and in_ready 1, and the next 16 rows form a complete block.
- Parametrisation. With NUM_CAND = 4, NUM_ROWS = 3, SAD_W = 8, apply random rows against a reference model in both ME_TREE_PIPE_EN builds. Expect matching results, with latency 3 vs 1 cycles.
